// File: rtl/control_turnos.sv
// rtl/control_turnos.sv - turn controller for a 3x3 board: validates moves, writes cells, detects win/draw
module control_turnos (
    input  logic       clk,
    input  logic       reset,
    input  logic       mov_valido,
    input  logic [3:0] mov_celda,
    input  logic       reiniciar,
    output logic [8:0] we_celda,
    output logic [5:0] dato_celda,
    output logic       listo,
    output logic       turno,
    output logic       mov_invalido,
    output logic       fin,
    output logic [1:0] ganador
);

    localparam logic [5:0] COD_VACIO = 6'd0;
    localparam logic [5:0] COD_X     = 6'd1;
    localparam logic [5:0] COD_O     = 6'd2;

    typedef enum logic [2:0] {
        LIMPIA,
        ESPERA,
        VALIDA,
        ESCRIBE,
        EVALUA,
        FIN
    } estado_t;

    estado_t          estado, estado_n;
    logic [8:0][1:0]  espejo, espejo_n;   // 00 empty, 01 X, 10 O
    logic [3:0]       cuenta, cuenta_n;
    logic [3:0]       celda, celda_n;

    logic [8:0]       we_n;
    logic [5:0]       dato_n;
    logic             listo_n, turno_n, inv_n, fin_n;
    logic [1:0]       ganador_n;

    logic [8:0]       sel;                 // one-hot of latched index, all zero when index > 8
    logic [8:0]       ocupadas;
    logic [1:0]       marca;

    // True when every cell of some row, column or diagonal holds code c
    function automatic logic hay_linea(input logic [8:0][1:0] m, input logic [1:0] c);
        logic [8:0] e;
        for (int i = 0; i < 9; i++) begin
            e[i] = (m[i] == c);
        end
        return (&e[2:0]) | (&e[5:3]) | (&e[8:6]) |
               (e[0] & e[3] & e[6]) | (e[1] & e[4] & e[7]) | (e[2] & e[5] & e[8]) |
               (e[0] & e[4] & e[8]) | (e[2] & e[4] & e[6]);
    endfunction

    // Decode latched index and occupancy for the validity check and write enable
    always_comb begin
        sel      = '0;
        ocupadas = '0;
        for (int i = 0; i < 9; i++) begin
            sel[i]      = (celda == 4'(i));
            ocupadas[i] = |espejo[i];
        end
        marca = turno ? 2'b10 : 2'b01;
    end

    // Next state and next registered outputs; reiniciar overrides every state but LIMPIA
    always_comb begin
        estado_n  = estado;
        we_n      = '0;
        dato_n    = COD_VACIO;
        listo_n   = listo;
        inv_n     = 1'b0;
        turno_n   = turno;
        fin_n     = fin;
        ganador_n = ganador;
        espejo_n  = espejo;
        cuenta_n  = cuenta;
        celda_n   = celda;
        if (reiniciar && (estado != LIMPIA)) begin
            // Enter LIMPIA with the clear strobe already on the cell registers
            estado_n  = LIMPIA;
            we_n      = 9'h1FF;
            listo_n   = 1'b0;
            turno_n   = 1'b0;
            fin_n     = 1'b0;
            ganador_n = 2'b00;
            espejo_n  = '0;
            cuenta_n  = '0;
        end else begin
            unique case (estado)
                LIMPIA: begin
                    turno_n   = 1'b0;
                    fin_n     = 1'b0;
                    ganador_n = 2'b00;
                    espejo_n  = '0;
                    cuenta_n  = '0;
                    listo_n   = 1'b0;
                    // After reset the strobe has not been issued yet; issue it, then leave
                    if (we_celda == 9'h1FF) begin
                        estado_n = ESPERA;
                        listo_n  = 1'b1;
                    end else begin
                        we_n = 9'h1FF;
                    end
                end
                ESPERA: begin
                    if (mov_valido) begin
                        celda_n  = mov_celda;
                        listo_n  = 1'b0;
                        estado_n = VALIDA;
                    end
                end
                VALIDA: begin
                    if ((sel == 9'd0) || ((sel & ocupadas) != 9'd0)) begin
                        inv_n    = 1'b1;
                        listo_n  = 1'b1;
                        estado_n = ESPERA;
                    end else begin
                        // Write strobe and mirror update land together so the mirror tracks the board
                        we_n     = sel;
                        dato_n   = turno ? COD_O : COD_X;
                        for (int i = 0; i < 9; i++) begin
                            if (sel[i]) begin
                                espejo_n[i] = marca;
                            end
                        end
                        cuenta_n = cuenta + 4'd1;
                        estado_n = ESCRIBE;
                    end
                end
                ESCRIBE: begin
                    estado_n = EVALUA;
                end
                EVALUA: begin
                    if (hay_linea(espejo, marca)) begin
                        fin_n     = 1'b1;
                        ganador_n = marca;
                        estado_n  = FIN;
                    end else if (cuenta == 4'd9) begin
                        fin_n     = 1'b1;
                        ganador_n = 2'b11;
                        estado_n  = FIN;
                    end else begin
                        turno_n  = ~turno;
                        listo_n  = 1'b1;
                        estado_n = ESPERA;
                    end
                end
                FIN: begin
                    listo_n = 1'b0;
                end
                default: begin
                    estado_n = LIMPIA;
                end
            endcase
        end
    end

    // State, mirror and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= LIMPIA;
            we_celda     <= '0;
            dato_celda   <= COD_VACIO;
            listo        <= 1'b0;
            turno        <= 1'b0;
            mov_invalido <= 1'b0;
            fin          <= 1'b0;
            ganador      <= 2'b00;
            espejo       <= '0;
            cuenta       <= '0;
            celda        <= '0;
        end else begin
            estado       <= estado_n;
            we_celda     <= we_n;
            dato_celda   <= dato_n;
            listo        <= listo_n;
            turno        <= turno_n;
            mov_invalido <= inv_n;
            fin          <= fin_n;
            ganador      <= ganador_n;
            espejo       <= espejo_n;
            cuenta       <= cuenta_n;
            celda        <= celda_n;
        end
    end

endmodule

// File: tb/tb_control_turnos.sv
// tb/tb_control_turnos.sv - self-checking bench for control_turnos with a board-level reference model
module tb_control_turnos;

    logic       clk = 1'b0;
    logic       reset;
    logic       mov_valido;
    logic [3:0] mov_celda;
    logic       reiniciar;
    logic [8:0] we_celda;
    logic [5:0] dato_celda;
    logic       listo;
    logic       turno;
    logic       mov_invalido;
    logic       fin;
    logic [1:0] ganador;

    int checks = 0;
    int errors = 0;

    // Reference model: board of player numbers (0 empty, 1 X, 2 O)
    int b[9];
    int jugador;
    bit terminado;
    int gan;
    int nmov;

    control_turnos dut (
        .clk          (clk),
        .reset        (reset),
        .mov_valido   (mov_valido),
        .mov_celda    (mov_celda),
        .reiniciar    (reiniciar),
        .we_celda     (we_celda),
        .dato_celda   (dato_celda),
        .listo        (listo),
        .turno        (turno),
        .mov_invalido (mov_invalido),
        .fin          (fin),
        .ganador      (ganador)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit gana(input int p);
        for (int r = 0; r < 3; r++) begin
            if (b[3*r] == p && b[3*r+1] == p && b[3*r+2] == p) return 1'b1;
            if (b[r] == p && b[r+3] == p && b[r+6] == p) return 1'b1;
        end
        if (b[0] == p && b[4] == p && b[8] == p) return 1'b1;
        if (b[2] == p && b[4] == p && b[6] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelo_limpiar();
        for (int i = 0; i < 9; i++) b[i] = 0;
        jugador   = 0;
        terminado = 1'b0;
        gan       = 0;
        nmov      = 0;
    endtask

    task automatic ciclo();
        @(negedge clk);
    endtask

    // One move request, checked cycle by cycle against the model
    task automatic mover(input int c);
        bit ok;
        int sim;
        if (terminado) begin
            mov_valido = 1'b1;
            mov_celda  = 4'(c);
            for (int k = 0; k < 4; k++) begin
                ciclo();
                mov_valido = 1'b0;
                chk("fin_we", we_celda, 9'h000);
                chk("fin_hold", fin, 1'b1);
                chk("fin_listo", listo, 1'b0);
            end
            return;
        end
        ok = 1'b0;
        if (c <= 8) ok = (b[c] == 0);
        sim = jugador + 1;
        mov_valido = 1'b1;
        mov_celda  = 4'(c);
        ciclo();
        mov_valido = 1'b0;
        chk("listo_drop", listo, 1'b0);
        ciclo();
        if (ok) begin
            chk("we_onehot", we_celda, 32'(1) << c);
            chk("dato_code", dato_celda, 32'(sim));
            chk("no_invalido", mov_invalido, 1'b0);
            b[c] = sim;
            nmov++;
            if (gana(sim)) begin
                terminado = 1'b1;
                gan = sim;
            end else if (nmov == 9) begin
                terminado = 1'b1;
                gan = 3;
            end else begin
                jugador = 1 - jugador;
            end
            ciclo();
            chk("we_single", we_celda, 9'h000);
            ciclo();
            chk("post_listo", listo, !terminado);
            chk("post_turno", turno, 32'(jugador));
            chk("post_fin", fin, terminado);
            chk("post_ganador", ganador, terminado ? 32'(gan) : 32'd0);
        end else begin
            chk("invalido_pulse", mov_invalido, 1'b1);
            chk("invalido_we", we_celda, 9'h000);
            chk("invalido_listo", listo, 1'b1);
            ciclo();
            chk("invalido_end", mov_invalido, 1'b0);
            chk("invalido_turno", turno, 32'(jugador));
        end
    endtask

    task automatic reiniciar_chk();
        reiniciar = 1'b1;
        ciclo();
        reiniciar = 1'b0;
        chk("clear_we", we_celda, 9'h1FF);
        chk("clear_dato", dato_celda, 6'd0);
        modelo_limpiar();
        ciclo();
        chk("clear_listo", listo, 1'b1);
        chk("clear_turno", turno, 1'b0);
        chk("clear_fin", fin, 1'b0);
        chk("clear_ganador", ganador, 2'b00);
        chk("clear_we_off", we_celda, 9'h000);
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        mov_valido = 1'b0;
        mov_celda  = 4'd0;
        reiniciar  = 1'b0;
        modelo_limpiar();
        repeat (3) ciclo();
        chk("rst_we", we_celda, 9'h000);
        chk("rst_dato", dato_celda, 6'd0);
        chk("rst_listo", listo, 1'b0);
        chk("rst_turno", turno, 1'b0);
        chk("rst_inv", mov_invalido, 1'b0);
        chk("rst_fin", fin, 1'b0);
        chk("rst_ganador", ganador, 2'b00);
        reset = 1'b0;
        ciclo();
        chk("boot_we", we_celda, 9'h1FF);
        chk("boot_dato", dato_celda, 6'd0);
        chk("boot_listo", listo, 1'b0);
        ciclo();
        chk("boot_listo_up", listo, 1'b1);
        chk("boot_we_off", we_celda, 9'h000);
        chk("boot_turno", turno, 1'b0);
        chk("boot_fin", fin, 1'b0);

        // Centre move, occupied cell, out-of-range index
        mover(4);
        mover(4);
        mover(12);

        // X wins on the top row, then nothing further is written
        reiniciar_chk();
        mover(0); mover(3); mover(1); mover(4); mover(2);
        chk("win_ganador", ganador, 2'b01);
        mover(8);
        reiniciar_chk();

        // Full board with no line
        mover(0); mover(1); mover(2); mover(4); mover(3);
        mover(5); mover(7); mover(6); mover(8);
        chk("draw_ganador", ganador, 2'b11);
        chk("draw_fin", fin, 1'b1);
        reiniciar_chk();

        // Abort during the write cycle
        mover(0);
        mov_valido = 1'b1;
        mov_celda  = 4'd7;
        ciclo();
        mov_valido = 1'b0;
        ciclo();
        chk("abort_we", we_celda, 9'h080);
        reiniciar_chk();
        mover(7);
        mover(0);

        // Reset mid-move discards the move and clears the board
        mov_valido = 1'b1;
        mov_celda  = 4'd5;
        ciclo();
        mov_valido = 1'b0;
        reset = 1'b1;
        ciclo();
        ciclo();
        reset = 1'b0;
        chk("rst_mid_listo", listo, 1'b0);
        ciclo();
        chk("rst_mid_we", we_celda, 9'h1FF);
        ciclo();
        chk("rst_mid_listo_up", listo, 1'b1);
        modelo_limpiar();
        mover(7);

        // Random games, including out-of-range indices
        for (int g = 0; g < 6; g++) begin
            reiniciar_chk();
            for (int s = 0; s < 30; s++) begin
                if (!terminado) begin
                    c = int'($urandom_range(0, 11));
                    if (c == 11) c = 15;
                    mover(c);
                end
            end
            if (terminado) mover(int'($urandom_range(0, 8)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_turnos.md
# control_turnos

Game-turn controller for the 3x3 board. Accepts move requests (cell index 0–8) from the input decoder. It validates each request against an internal occupancy map and writes the current player's symbol code into the addressed 6-bit cell register via a one-hot write enable. After each move it checks for three-in-a-row and detects a draw, then either alternates the turn or ends the game. It sits between the button/keypad decoder and the nine board cell registers that feed the display logic.

## Interface
- COD_VACIO, 6'd0, cell code written for an empty cell
- COD_X, 6'd1, cell code for player X
- COD_O, 6'd2, cell code for player O
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mov_valido  in  1  move request strobe, sampled only while listo=1
- mov_celda  in  4  requested cell index, row-major, 0 = top-left
- reiniciar  in  1  new-game request, honoured in any state except LIMPIA
- we_celda  out  9  one-hot (or all-ones on clear) write enable to cell registers, bit i = cell i
- dato_celda  out  6  code driven to all cell registers, valid whenever any we_celda bit is set
- listo  out  1  controller waiting for a move
- turno  out  1  0 = X to move, 1 = O to move
- mov_invalido  out  1  one-cycle pulse when a request is rejected
- fin  out  1  game over, held until reiniciar or reset
- ganador  out  2  00 none, 01 X, 10 O, 11 draw; valid while fin=1

## Operation
- All outputs are registered. Occupancy mirror: 9×2 bits (00 empty, 01 X, 10 O) plus a 4-bit move counter.
- States: LIMPIA, ESPERA, VALIDA, ESCRIBE, EVALUA, FIN.
- LIMPIA: we_celda=9'h1FF, dato_celda=COD_VACIO for exactly one cycle. Clears the mirror, sets the counter to 0, turno=0, fin=0, ganador=00. Next state is ESPERA.
- ESPERA: listo=1. If mov_valido=1, latch mov_celda and go to VALIDA. Otherwise stay.
- VALIDA: if the latched index is >8 or the mirror cell is non-empty, pulse mov_invalido and return to ESPERA. turno and the counter are unchanged. Otherwise go to ESCRIBE.
- ESCRIBE: assert the one-hot we_celda bit for the latched index. dato_celda = COD_X if turno=0, else COD_O. Update the mirror and increment the counter. Go to EVALUA.
- EVALUA: check 8 lines (3 rows, 3 columns, 2 diagonals) in the updated mirror for the current player.
  - Line found: ganador = 01 (X) or 10 (O), go to FIN.
  - No line and counter = 9: ganador = 11, go to FIN.
  - Otherwise: toggle turno, go to ESPERA.
- FIN: fin=1, listo=0. mov_valido is ignored.
- reiniciar=1 in any state other than LIMPIA forces LIMPIA on the next cycle. It takes priority over every other transition, including an in-progress ESCRIBE.
- A win on the 9th move reports the winner, not a draw.

## Timing
- Reset values: we_celda=0, dato_celda=COD_VACIO, listo=0, turno=0, mov_invalido=0, fin=0, ganador=00, state=LIMPIA.
- The first cycle after reset deasserts performs the board clear. listo rises one cycle later.
- Valid move, mov_valido sampled high at edge N:
  - VALIDA during N+1.
  - we_celda pulse during N+2.
  - EVALUA during N+3.
  - At N+4, either listo=1 with turno toggled, or fin=1 with ganador set.
- Rejected move: mov_invalido is high during N+2 only, and listo=1 again from N+2.
- listo drops the cycle after a request is accepted. mov_valido asserted while listo=0 is dropped, not queued.
- we_celda is never high for more than one consecutive cycle.
- A reset asserted mid-move discards the move. The board is cleared via LIMPIA after reset.

## Test plan
- Reset then idle → one cycle with we_celda=9'h1FF and dato_celda=0, then listo=1, turno=0, fin=0.
- X requests cell 4 → we_celda=9'h010 and dato_celda=1 at N+2, then turno=1 and listo=1 at N+4. O requests cell 4 → mov_invalido one-cycle pulse, turno stays 1, no we_celda.
- mov_celda=4'd12 → mov_invalido pulse, no write.
- Moves X0, O3, X1, O4, X2 → after the 5th move, fin=1, ganador=01, listo=0. A further mov_valido produces no write.
- Draw sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 → fin=1, ganador=11 after the 9th write.
- reiniciar asserted during ESCRIBE of a move, and again while in FIN → next cycle we_celda=9'h1FF, then listo=1, turno=0, ganador=00. The mirror is empty, so a move to a previously used cell is accepted.
